// File: rtl/hub75_pkg.sv
// Shared constants, types and helpers for the HUB75 line fetch and scan stages.
package hub75_pkg;

  localparam int unsigned COLS       = 64;
  localparam int unsigned ROWS_HALF  = 32;
  localparam int unsigned COLOR_BITS = 4;

  // RGB444 field positions inside a framebuffer word.
  localparam int unsigned R_MSB = 11;
  localparam int unsigned G_MSB = 7;
  localparam int unsigned B_MSB = 3;
  localparam int unsigned R_LSB = R_MSB - COLOR_BITS + 1;
  localparam int unsigned G_LSB = G_MSB - COLOR_BITS + 1;
  localparam int unsigned B_LSB = B_MSB - COLOR_BITS + 1;

  // Bit order of a single-plane pixel {R,G,B} on the shifter side.
  localparam int unsigned RGB_R = 2;
  localparam int unsigned RGB_G = 1;
  localparam int unsigned RGB_B = 0;

  // FIFO entry: {rgb0[2:0], rgb1[2:0], last}.
  localparam int unsigned PAIR_W = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRdTop,
    StRdBot,
    StDrain
  } line_state_e;

  // Pick one bit-plane out of an RGB444 word.
  function automatic logic [2:0] plane_bits(input logic [3*COLOR_BITS-1:0] px,
                                            input logic [$clog2(COLOR_BITS)-1:0] plane);
    logic [3*COLOR_BITS-1:0] sh;
    logic [2:0]              rgb;
    sh         = px >> plane;
    rgb[RGB_R] = sh[R_LSB];
    rgb[RGB_G] = sh[G_LSB];
    rgb[RGB_B] = sh[B_LSB];
    return rgb;
  endfunction

endpackage

// File: rtl/hub75_pair_fifo.sv
// Small synchronous FIFO for single-plane pixel pairs, with occupancy output.
module hub75_pair_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 7,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Storage, pointers and occupancy; reset flushes everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/hub75_line_fetch.sv
// Fetches one HUB75 line (top and bottom half) from the framebuffer, extracts a
// bit-plane and streams pixel pairs to the shifter through a credit-guarded FIFO.
module hub75_line_fetch #(
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS_HALF  = 32,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned ColW   = $clog2(COLS),
  localparam int unsigned RowW   = $clog2(ROWS_HALF),
  localparam int unsigned PlaneW = $clog2(COLOR_BITS),
  localparam int unsigned AddrW  = 1 + RowW + ColW,
  localparam int unsigned DataW  = 3 * COLOR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [RowW-1:0]   req_row,
  input  logic [PlaneW-1:0] req_plane,
  output logic              mem_rd_en,
  output logic [AddrW-1:0]  mem_addr,
  input  logic [DataW-1:0]  mem_rdata,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [2:0]        px_rgb0,
  output logic [2:0]        px_rgb1,
  output logic              px_last,
  output logic              busy
);

  import hub75_pkg::*;

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  line_state_e       state_q;
  logic [RowW-1:0]   row_q;
  logic [PlaneW-1:0] plane_q;
  logic [ColW-1:0]   col_q;
  logic              rd_en_q;
  logic [AddrW-1:0]  addr_q;

  logic              top_pend_q, bot_pend_q, last_pend_q;
  logic [DataW-1:0]  top_hold_q;
  logic [CntW-1:0]   inflight_q, inflight_d;

  logic [CntW-1:0]   fifo_count, count_next;
  logic [CntW:0]     commit_next;
  logic              fifo_empty;
  logic [PAIR_W-1:0] push_data, head;
  logic              push, pop, credit_next, col_last, inflight_inc;

  assign col_last     = (col_q == ColW'(COLS - 1));
  assign push         = bot_pend_q;
  assign pop          = !fifo_empty && px_ready;
  assign inflight_inc = (state_q == StRdBot);

  // Next-cycle occupancy: a read may only be issued if the pair it starts still fits.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({inflight_inc, push})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
    count_next = fifo_count;
    unique case ({push, pop})
      2'b10:   count_next = fifo_count + CntW'(1);
      2'b01:   count_next = fifo_count - CntW'(1);
      default: count_next = fifo_count;
    endcase
    commit_next = {1'b0, count_next} + {1'b0, inflight_d};
    credit_next = (commit_next < (CntW + 1)'(FIFO_DEPTH));
  end

  // Line FSM with registered read strobe and address; credit is pre-evaluated
  // for the cycle in which the top read would go out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      plane_q <= '0;
      col_q   <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rd_en_q <= 1'b0;
          if (req_valid) begin
            row_q   <= req_row;
            plane_q <= req_plane;
            col_q   <= '0;
            state_q <= StRdTop;
            rd_en_q <= credit_next;
            addr_q  <= {1'b0, req_row, ColW'(0)};
          end
        end
        StRdTop: begin
          if (rd_en_q) begin
            state_q <= StRdBot;
            addr_q  <= {1'b1, row_q, col_q};
          end else begin
            rd_en_q <= credit_next;
          end
        end
        StRdBot: begin
          if (col_last) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end else begin
            col_q   <= col_q + ColW'(1);
            state_q <= StRdTop;
            rd_en_q <= credit_next;
            addr_q  <= {1'b0, row_q, col_q + ColW'(1)};
          end
        end
        StDrain: begin
          // Only the final pair carries last, so its pop means the line is done.
          if (pop && head[0]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read-return tracking: capture top data, then push the pair with the bottom data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_pend_q  <= 1'b0;
      bot_pend_q  <= 1'b0;
      last_pend_q <= 1'b0;
      top_hold_q  <= '0;
      inflight_q  <= '0;
    end else begin
      top_pend_q  <= (state_q == StRdTop) && rd_en_q;
      bot_pend_q  <= (state_q == StRdBot);
      last_pend_q <= (state_q == StRdBot) && col_last;
      if (top_pend_q) top_hold_q <= mem_rdata;
      inflight_q  <= inflight_d;
    end
  end

  assign push_data = {plane_bits(top_hold_q, plane_q), plane_bits(mem_rdata, plane_q),
                      last_pend_q};

  hub75_pair_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(PAIR_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (pop),
    .data_o (head),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign px_valid  = !fifo_empty;
  // Present zeros when nothing is queued so stale entries never leak out.
  assign px_rgb0   = fifo_empty ? 3'b000 : head[6:4];
  assign px_rgb1   = fifo_empty ? 3'b000 : head[3:1];
  assign px_last   = fifo_empty ? 1'b0 : head[0];

endmodule
